// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared constants and helpers for the button conditioner
package button_conditioner_pkg;

  // Defaults for a 100 MHz board clock: 500 us sample tick, ~100 ms press qualification.
  localparam int BTN_SAMPLE_CNT_MAX = 50000;
  localparam int BTN_PULSE_CNT_MAX  = 200;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_debouncer.sv
// rtl/button_conditioner_debouncer.sv - per-bit saturating debounce counters and level compare
module debouncer
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int PULSE_CNT_MAX = BTN_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] level
);

  localparam int              SAT_W   = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SAT_W-1:0] SAT_MAX = SAT_W'(PULSE_CNT_MAX);

  logic [WIDTH-1:0][SAT_W-1:0] sat_q;
  logic [WIDTH-1:0][SAT_W-1:0] sat_d;

  // Any low sample aborts the count; high samples advance on tick until saturation.
  always_comb begin
    sat_d = sat_q;
    level = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!s2[i]) begin
        sat_d[i] = '0;
      end else if (tick && (sat_q[i] < SAT_MAX)) begin
        sat_d[i] = sat_q[i] + SAT_W'(1);
      end
      level[i] = (sat_q[i] == SAT_MAX);
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and edge-detect raw pushbuttons
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = BTN_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = BTN_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] button_in,
  output logic [WIDTH-1:0] button_level,
  output logic [WIDTH-1:0] button_pulse
);

  localparam int               CNT_W    = min1_clog2(SAMPLE_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CNT_MAX - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic             tick;

  // Two-flop synchronizer, shared free-running sample counter and rising-edge detect.
  always_comb begin
    s1_d         = button_in;
    s2_d         = s1_q;
    tick         = (cnt_q == CNT_LAST);
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    lvl_d        = button_level;
    button_pulse = button_level & ~lvl_q;
  end

  // State registers; reset discards any debounce progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
      lvl_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  debouncer #(
    .WIDTH         (WIDTH),
    .PULSE_CNT_MAX (PULSE_CNT_MAX)
  ) u_debouncer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .s2    (s2_q),
    .level (button_level)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] button_in;
  logic [3:0] button_level;
  logic [3:0] button_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pcnt [4] = '{0, 0, 0, 0};
  int p0, p1, p2, p3;

  always #5 clk = ~clk;

  button_conditioner #(
    .WIDTH          (4),
    .SAMPLE_CNT_MAX (4),
    .PULSE_CNT_MAX  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_in    (button_in),
    .button_level (button_level),
    .button_pulse (button_pulse)
  );

  // Count every cycle each pulse bit is high, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (button_pulse[i] === 1'b1) pcnt[i] <= pcnt[i] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic snap();
    p0 = pcnt[0];
    p1 = pcnt[1];
    p2 = pcnt[2];
    p3 = pcnt[3];
  endtask

  initial begin
    rst_n     = 1'b0;
    button_in = 4'hF;

    // 1. Reset held with all buttons pressed
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_level", button_level, 4'h0);
      check_eq("rst_pulse", button_pulse, 4'h0);
    end
    rst_n = 1'b1;
    cyc   = 0;
    snap();
    run_to(11);
    check_eq("rst_lvl_c11", button_level, 4'h0);
    run_to(12);
    check_eq("rst_lvl_c12", button_level, 4'hF);
    check_eq("rst_pulse_c12", button_pulse, 4'hF);
    run_to(13);
    check_eq("rst_pulse_c13", button_pulse, 4'h0);
    run_to(16);
    button_in = 4'h0;
    run_to(19);
    check_eq("rst_release", button_level, 4'h0);
    run_to(20);
    check_eq("rst_pulse_count0", pcnt[0] - p0, 1);

    // 2. Clean press on bit 1
    snap();
    button_in = 4'b0010;
    run_to(31);
    check_eq("press_lvl_c31", button_level, 4'h0);
    run_to(32);
    check_eq("press_lvl_c32", button_level, 4'b0010);
    check_eq("press_pulse_c32", button_pulse, 4'b0010);
    run_to(33);
    check_eq("press_pulse_c33", button_pulse, 4'h0);
    check_eq("press_lvl_c33", button_level, 4'b0010);

    // 3. Release: level falls exactly three edges later
    run_to(60);
    button_in = 4'h0;
    run_to(62);
    check_eq("rel_lvl_c62", button_level, 4'b0010);
    run_to(63);
    check_eq("rel_lvl_c63", button_level, 4'h0);
    check_eq("rel_pulse_c63", button_pulse, 4'h0);
    run_to(64);
    check_eq("press_pulse_count1", pcnt[1] - p1, 1);
    check_eq("press_other_bits", (pcnt[0] - p0) + (pcnt[2] - p2) + (pcnt[3] - p3), 0);

    // 4. Bounce: 6 high, 1 low, then high again
    run_to(100);
    snap();
    button_in = 4'b0010;
    run_to(106);
    button_in = 4'b0000;
    run_to(107);
    button_in = 4'b0010;
    run_to(112);
    check_eq("bounce_lvl_c112", button_level, 4'h0);
    run_to(119);
    check_eq("bounce_lvl_c119", button_level, 4'h0);
    run_to(120);
    check_eq("bounce_lvl_c120", button_level, 4'b0010);
    check_eq("bounce_pulse_c120", button_pulse, 4'b0010);
    run_to(130);
    button_in = 4'h0;
    run_to(134);
    check_eq("bounce_pulse_count", pcnt[1] - p1, 1);

    // 5. Simultaneous press on bits 0 and 3
    run_to(140);
    snap();
    button_in = 4'b1001;
    run_to(151);
    check_eq("simul_lvl_c151", button_level, 4'h0);
    run_to(152);
    check_eq("simul_lvl_c152", button_level, 4'b1001);
    check_eq("simul_pulse_c152", button_pulse, 4'b1001);
    run_to(153);
    check_eq("simul_pulse_c153", button_pulse, 4'h0);
    run_to(160);
    button_in = 4'h0;
    run_to(164);
    check_eq("simul_count0", pcnt[0] - p0, 1);
    check_eq("simul_count3", pcnt[3] - p3, 1);
    check_eq("simul_count12", (pcnt[1] - p1) + (pcnt[2] - p2), 0);

    // 6. Reset mid-count on bit 2, just before the third tick
    run_to(170);
    snap();
    button_in = 4'b0100;
    run_to(182);
    rst_n = 1'b0;
    run_to(183);
    check_eq("midrst_lvl_c183", button_level, 4'h0);
    check_eq("midrst_pulse_c183", button_pulse, 4'h0);
    rst_n = 1'b1;
    run_to(184);
    check_eq("midrst_lvl_c184", button_level, 4'h0);
    check_eq("midrst_pulse_c184", button_pulse, 4'h0);
    run_to(194);
    check_eq("midrst_lvl_c194", button_level, 4'h0);
    run_to(195);
    check_eq("midrst_lvl_c195", button_level, 4'b0100);
    check_eq("midrst_pulse_c195", button_pulse, 4'b0100);
    run_to(196);
    check_eq("midrst_pulse_c196", button_pulse, 4'h0);
    run_to(200);
    check_eq("midrst_pulse_count", pcnt[2] - p2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
